// File: rtl/ps2_rx_if.sv
// ps2_rx_if: show-ahead byte read port of the PS/2 receiver FIFO
interface ps2_rx_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with clock glitch filter, frame timeout and show-ahead byte FIFO
module ps2_rx #(
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int FIFO_AW        = 3
) (
    input  logic     clk_core,
    input  logic     reset,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    input  logic     inhibit,
    input  logic     clr_err,
    output logic     parity_err,
    output logic     framing_err,
    output logic     overflow,
    ps2_rx_if.master rd
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           clk_sync, dat_sync;
    logic                 clean_clk, accept, fall, dat, timeout;
    logic [FW-1:0]        flt_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 push, set_par, set_frm;
    logic [7:0]           mem [2**FIFO_AW];
    logic [FIFO_AW:0]     wp, rp;
    logic                 empty, full, pop, wr;

    assign dat     = dat_sync[1];
    assign accept  = clk_sync[1] != clean_clk && flt_cnt == FW'(FILTER_CYCLES - 1);
    assign fall    = accept && clean_clk;
    assign timeout = state_q != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES);

    always_ff @(posedge clk_core) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            clean_clk <= 1'b1;
            flt_cnt   <= '0;
            tmo_cnt   <= '0;
            state_q   <= IDLE;
            bit_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_data};
            clean_clk <= accept ? clk_sync[1] : clean_clk;
            flt_cnt   <= (clk_sync[1] == clean_clk || accept) ? '0 : flt_cnt + 1'b1;
            tmo_cnt   <= (state_d == IDLE || fall) ? '0 : tmo_cnt + 1'b1;
            state_q   <= state_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
        end
    end

    // inhibit outranks timeout, which outranks a coincident fall
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        push    = 1'b0;
        set_par = 1'b0;
        set_frm = 1'b0;
        if (inhibit) begin
            state_d = IDLE;
            bit_d   = '0;
        end else if (timeout) begin
            state_d = IDLE;
            bit_d   = '0;
            set_frm = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d = dat ? IDLE : DATA;
                    bit_d   = '0;
                end
                DATA: begin
                    sh_d    = {dat, sh_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    state_d = bit_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    push    = dat && ^{sh_q, par_q};
                    set_par = dat && !(^{sh_q, par_q});
                    set_frm = !dat;
                end
            endcase
        end
    end

    assign empty       = wp == rp;
    assign full        = wp[FIFO_AW] != rp[FIFO_AW] && wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0];
    assign pop         = rd.rd_ready && !empty;
    assign wr          = push && (!full || pop);
    assign rd.rd_valid = !empty;
    assign rd.rd_data  = mem[rp[FIFO_AW-1:0]];

    always_ff @(posedge clk_core) begin
        if (wr) mem[wp[FIFO_AW-1:0]] <= sh_q;
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            wp          <= '0;
            rp          <= '0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wp          <= wr ? wp + 1'b1 : wp;
            rp          <= pop ? rp + 1'b1 : rp;
            parity_err  <= set_par || (parity_err && !clr_err);
            framing_err <= set_frm || (framing_err && !clr_err);
            overflow    <= (push && full && !pop) || (overflow && !clr_err);
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed vector table, corner sequences and randomized frames against a queue model
module tb_ps2_rx;
    logic clk_core = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic inhibit = 1'b0, clr_err = 1'b0;
    logic parity_err, framing_err, overflow;
    int   checks = 0, failures = 0;

    ps2_rx_if rd();

    ps2_rx dut (
        .clk_core(clk_core), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .inhibit(inhibit), .clr_err(clr_err), .parity_err(parity_err),
        .framing_err(framing_err), .overflow(overflow), .rd(rd)
    );

    always #5 clk_core = ~clk_core;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic       ev;
        logic [7:0] eh;
        logic       ep;
        logic       ef;
    } vec_t;

    vec_t tv[10];

    byte unsigned q[$];
    logic m_perr, m_ferr, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_core);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic send_raw(input logic [10:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(half);
            ps2_clk = 1'b0;
            wait_cyc(half);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int half);
        send_raw({stop, par, d, 1'b0}, 11, half);
        wait_cyc(half);
    endtask

    // leaves the bench at the negedge just before the clock edge that completes the stop bit
    task automatic arm_stop(input logic [7:0] d, input logic par, input int half);
        send_raw({1'b1, par, d, 1'b0}, 10, half);
        ps2_data = 1'b1;
        wait_cyc(half);
        ps2_clk = 1'b0;
        repeat (5) @(posedge clk_core);
        @(negedge clk_core);
    endtask

    task automatic finish_stop(input int half);
        wait_cyc(half);
        ps2_clk = 1'b1;
        wait_cyc(half);
    endtask

    task automatic pop1();
        rd.rd_ready = 1'b1;
        wait_cyc(1);
        rd.rd_ready = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic clr();
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        q.delete();
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
        if (!stop) m_ferr = 1'b1;
        else if ($countones({d, par}) % 2 == 0) m_perr = 1'b1;
        else if (q.size() == 8) m_ovf = 1'b1;
        else q.push_back(d);
    endtask

    task automatic check_all(input string name);
        chk({name, "_valid"}, rd.rd_valid, q.size() > 0);
        if (q.size() > 0) chk({name, "_data"}, rd.rd_data, q[0]);
        chk({name, "_perr"}, parity_err, m_perr);
        chk({name, "_ferr"}, framing_err, m_ferr);
        chk({name, "_ovf"}, overflow, m_ovf);
    endtask

    initial begin
        rd.rd_ready = 1'b0;
        tv[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0};
        tv[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
        tv[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
        tv[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tv[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        tv[7] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[8] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[9] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

        do_reset();
        chk("rst_valid", rd.rd_valid, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_ferr", framing_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);

        // 200-cycle bit period, push latency and single pop
        arm_stop(8'h1C, 1'b0, 100);
        chk("lat_pre_valid", rd.rd_valid, 1'b0);
        wait_cyc(1);
        chk("lat_post_valid", rd.rd_valid, 1'b1);
        chk("lat_post_data", rd.rd_data, 8'h1C);
        finish_stop(100);
        chk("f1c_perr", parity_err, 1'b0);
        chk("f1c_ferr", framing_err, 1'b0);
        pop1();
        chk("f1c_pop_valid", rd.rd_valid, 1'b0);

        foreach (tv[i]) begin
            send_frame(tv[i].d, tv[i].par, tv[i].stop, 40);
            chk($sformatf("tv%0d_valid", i), rd.rd_valid, tv[i].ev);
            if (tv[i].ev) chk($sformatf("tv%0d_data", i), rd.rd_data, tv[i].eh);
            chk($sformatf("tv%0d_perr", i), parity_err, tv[i].ep);
            chk($sformatf("tv%0d_ferr", i), framing_err, tv[i].ef);
            chk($sformatf("tv%0d_ovf", i), overflow, 1'b0);
            if (tv[i].ev) pop1();
            chk($sformatf("tv%0d_empty", i), rd.rd_valid, 1'b0);
            clr();
            chk($sformatf("tv%0d_clr_perr", i), parity_err, 1'b0);
            chk($sformatf("tv%0d_clr_ferr", i), framing_err, 1'b0);
        end

        // set beats a coincident clear
        arm_stop(8'h1C, 1'b1, 40);
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        finish_stop(40);
        chk("setwin_perr", parity_err, 1'b1);
        clr();

        // pops on an empty FIFO are ignored
        rd.rd_ready = 1'b1;
        wait_cyc(3);
        rd.rd_ready = 1'b0;
        send_frame(8'h3C, good_par(8'h3C), 1'b1, 40);
        chk("emptypop_valid", rd.rd_valid, 1'b1);
        chk("emptypop_data", rd.rd_data, 8'h3C);
        pop1();
        chk("emptypop_after", rd.rd_valid, 1'b0);

        // overflow: nine frames, eight survive
        do_reset();
        for (int d = 1; d <= 9; d++) send_frame(8'(d), good_par(8'(d)), 1'b1, 40);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_perr", parity_err, 1'b0);
        for (int d = 1; d <= 8; d++) begin
            chk($sformatf("ovf_valid%0d", d), rd.rd_valid, 1'b1);
            chk($sformatf("ovf_data%0d", d), rd.rd_data, 8'(d));
            pop1();
        end
        chk("ovf_drained", rd.rd_valid, 1'b0);

        // timeout after a partial frame
        do_reset();
        send_raw(11'b000_0000_1010, 4, 40);
        wait_cyc(2500);
        chk("tmo_ferr", framing_err, 1'b1);
        chk("tmo_perr", parity_err, 1'b0);
        chk("tmo_valid", rd.rd_valid, 1'b0);
        clr();
        send_frame(8'hF0, 1'b1, 1'b1, 40);
        chk("tmo_next_valid", rd.rd_valid, 1'b1);
        chk("tmo_next_data", rd.rd_data, 8'hF0);
        chk("tmo_next_ferr", framing_err, 1'b0);
        pop1();

        // glitch rejection, then inhibit mid-frame
        do_reset();
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(20);
        chk("glitch_valid", rd.rd_valid, 1'b0);
        chk("glitch_ferr", framing_err, 1'b0);
        chk("glitch_perr", parity_err, 1'b0);
        send_raw(11'b000_0001_0110, 5, 40);
        inhibit = 1'b1;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(60);
        ps2_clk = 1'b1;
        wait_cyc(20);
        inhibit = 1'b0;
        wait_cyc(20);
        chk("inh_valid", rd.rd_valid, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1, 40);
        chk("inh_next_valid", rd.rd_valid, 1'b1);
        chk("inh_next_data", rd.rd_data, 8'h5A);
        chk("inh_perr", parity_err, 1'b0);
        chk("inh_ferr", framing_err, 1'b0);
        pop1();
        chk("inh_single", rd.rd_valid, 1'b0);

        // reset mid-frame
        send_raw(11'b000_0001_1010, 5, 40);
        do_reset();
        send_frame(8'h33, good_par(8'h33), 1'b1, 40);
        chk("rstmid_valid", rd.rd_valid, 1'b1);
        chk("rstmid_data", rd.rd_data, 8'h33);
        chk("rstmid_ferr", framing_err, 1'b0);
        pop1();

        // push and pop together while full
        do_reset();
        for (int d = 8'h11; d <= 8'h18; d++) send_frame(8'(d), good_par(8'(d)), 1'b1, 40);
        arm_stop(8'h19, good_par(8'h19), 40);
        rd.rd_ready = 1'b1;
        wait_cyc(1);
        rd.rd_ready = 1'b0;
        finish_stop(40);
        chk("fullpp_ovf", overflow, 1'b0);
        for (int d = 8'h12; d <= 8'h19; d++) begin
            chk($sformatf("fullpp_valid%0h", d), rd.rd_valid, 1'b1);
            chk($sformatf("fullpp_data%0h", d), rd.rd_data, 8'(d));
            pop1();
        end
        chk("fullpp_drained", rd.rd_valid, 1'b0);

        // randomized frames against the queue model
        do_reset();
        for (int n = 0; n < 25; n++) begin
            logic [7:0] d;
            logic par, stop;
            int r;
            d = 8'($urandom);
            r = $urandom_range(0, 9);
            stop = r != 0;
            par = (r == 1) ? !good_par(d) : good_par(d);
            send_frame(d, par, stop, 40);
            model_frame(d, par, stop);
            check_all($sformatf("rnd%0d", n));
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                pop1();
                check_all($sformatf("rnd%0d_pop", n));
            end
            if ($urandom_range(0, 4) == 0) begin
                clr();
                check_all($sformatf("rnd%0d_clr", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 4: consecutive cycles a synchronized PS/2 clock level must hold before it is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000: cycles without an accepted clock edge before an in-progress frame is abandoned.
REQ-003 SHALL have parameter FIFO_AW, default 3: FIFO depth is 2**FIFO_AW bytes.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk_core  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ps2_clk  in  1  raw PS/2 clock pin level, asynchronous.
REQ-008 ps2_data  in  1  raw PS/2 data pin level, asynchronous.
REQ-009 inhibit  in  1  host is holding the PS/2 clock low; discards any frame in progress.
REQ-010 rd_data  out  8  FIFO head byte; valid only while rd_valid=1.
REQ-011 rd_valid  out  1  FIFO is not empty.
REQ-012 rd_ready  in  1  pops the head when rd_valid=1.
REQ-013 parity_err  out  1  sticky: a frame failed the odd-parity check.
REQ-014 framing_err  out  1  sticky: a frame had a bad stop bit or timed out.
REQ-015 overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
REQ-016 clr_err  in  1  clears all three sticky flags.

Function
REQ-017 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; both flops idle at 1.
REQ-018 SHALL maintain clean_clk, which takes the synchronized clock value only after that value has differed from clean_clk for FILTER_CYCLES consecutive cycles; a shorter excursion resets the filter count and causes no change.
REQ-019 SHALL assert the single-cycle strobe fall in the cycle clean_clk transitions from 1 to 0; the synchronized data is sampled in that same cycle.
REQ-020 SHALL implement the states IDLE, DATA, PARITY and STOP.
REQ-021 IDLE: on fall with data=0, SHALL go to DATA with bit count 0; on fall with data=1, SHALL stay in IDLE and flag nothing.
REQ-022 DATA: on each fall SHALL shift data in LSB first; on the 8th bit SHALL go to PARITY.
REQ-023 PARITY: on fall SHALL capture the parity bit and go to STOP.
REQ-024 STOP: on fall SHALL return to IDLE and take exactly one of these actions:
  - stop=1 and odd parity good: push the byte;
  - stop=1 and parity bad: set parity_err, no push;
  - stop=0: set framing_err, no push, regardless of parity.
REQ-025 SHALL count cycles while not in IDLE, clearing the count on each fall; when the count reaches TIMEOUT_CYCLES, SHALL go to IDLE and set framing_err.
REQ-026 inhibit=1 SHALL force IDLE and clear the bit and timeout counters in the same cycle, set no flag, and override a simultaneous fall.
REQ-027 Push latency: rd_valid SHALL be 1 in the cycle after the STOP fall when the FIFO was empty, with rd_data equal to the received byte.
REQ-028 FIFO SHALL be show-ahead: rd_data presents the head combinationally from storage, and a pop advances it on the next cycle.
REQ-029 Push while full with no pop SHALL drop the new byte, set overflow and leave the FIFO contents unchanged.
REQ-030 Push and pop in the same cycle while full SHALL accept both, with no overflow.
REQ-031 Push and pop in the same cycle while not empty SHALL leave the occupancy unchanged.
REQ-032 rd_ready with rd_valid=0 SHALL be ignored.
REQ-033 Pointers SHALL be FIFO_AW+1 bits wide and wrap modulo 2**(FIFO_AW+1); full = MSBs differ and the rest are equal.
REQ-034 When clr_err coincides with a flag-setting event, set SHALL win.

Reset
REQ-035 reset=1 SHALL set on the next edge: state IDLE; bit, filter and timeout counters 0; shift register 0; synchronizers and clean_clk 1.
REQ-036 reset=1 SHALL also set: FIFO pointers 0; rd_valid, parity_err, framing_err and overflow all 0.
REQ-037 rd_data after reset SHALL be don't-care.
REQ-038 Reset mid-frame SHALL discard the partial byte, and the first frame after release SHALL decode normally.

Verification
REQ-039 Frame 0x1C, parity 0, stop 1, bit period 200 cycles -> rd_valid=1, rd_data=0x1C, no flags; rd_ready for 1 cycle -> rd_valid=0.
REQ-040 Frame 0x1C with parity 1 -> parity_err=1, rd_valid stays 0; clr_err -> parity_err=0.
REQ-041 Nine good frames 0x01..0x09 with no pop -> overflow=1; eight pops yield 0x01..0x08, then rd_valid=0.
REQ-042 Start bit plus 3 data bits, then 2000 idle cycles -> framing_err=1, state IDLE; next frame 0xF0 with parity 1 -> rd_data=0xF0.
REQ-043 3-cycle low glitch on ps2_clk while idle -> no state change, no flag; inhibit=1 mid-frame, then release and send 0x5A with parity 1 -> only 0x5A is queued, no flags.
REQ-044 Pop in the same cycle as a push while the FIFO holds 8 bytes -> overflow=0, occupancy stays 8, and the new byte is last out.
